// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
// Exports: MODE_* output-mode codes, MIN_DIV, high_len() square-wave helper.
package clkdiv_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    localparam int MIN_DIV = 2;

    // Cycles the square output stays high for divisor d.
    // Odd divisors give the extra cycle to the high phase.
    function automatic logic [31:0] high_len(input logic [31:0] d);
        return d - (d >> 1);
    endfunction

endpackage

// File: rtl/clkdiv_prog_ch.sv
// One divider channel: counter, active/pending divisor, output registers.
// Ports: clkin, rst_n, en, load, div_in[WIDTH], mode -> tick, clkout, div_err.
module clkdiv_prog_ch
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIV_DEFAULT = 50000
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             tick,
    output logic             clkout,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DIV_DEFAULT);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] pending;
    logic             pend_vld;

    logic             at_term;
    logic             load_ok;
    logic             load_bad;
    logic             apply;
    logic [WIDTH-1:0] high;

    assign at_term  = (count == active - WIDTH'(1));
    assign load_ok  = load && (div_in >= WIDTH'(MIN_DIV));
    assign load_bad = load && !load_ok;
    assign high     = WIDTH'(high_len(32'(active)));

    // Swap only at a wrap while running so the old period always
    // completes; when stopped there is no period to protect.
    assign apply = pend_vld && (!en || at_term);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            active   <= DEF;
            pending  <= DEF;
            pend_vld <= 1'b0;
            tick     <= 1'b0;
            clkout   <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            if (en) begin
                count <= at_term ? '0 : count + WIDTH'(1);
            end else begin
                count <= '0;
            end

            tick <= en && at_term;

            if (mode == MODE_SQUARE) begin
                clkout <= en && (count < high);
            end else begin
                clkout <= en && at_term;
            end

            // Apply uses the value pending before this edge; a load on
            // the same edge stays pending for the following wrap.
            if (apply) begin
                active <= pending;
            end
            if (load_ok) begin
                pending <= div_in;
            end
            pend_vld <= load_ok || (pend_vld && !apply);

            if (load_ok) begin
                div_err <= 1'b0;
            end else if (load_bad) begin
                div_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider / tick generator.
// Ports: clkin, rst_n, en/load/mode[N_CH], div_in[N_CH*WIDTH] -> tick, clkout, div_err[N_CH].
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int DIV_DEFAULT = 50000
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*WIDTH-1:0] div_in,
    input  logic [N_CH-1:0]       mode,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       clkout,
    output logic [N_CH-1:0]       div_err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clkdiv_prog_ch #(
            .WIDTH       (WIDTH),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .clkin   (clkin),
            .rst_n   (rst_n),
            .en      (en[i]),
            .load    (load[i]),
            .div_in  (div_in[i*WIDTH +: WIDTH]),
            .mode    (mode[i]),
            .tick    (tick[i]),
            .clkout  (clkout[i]),
            .div_err (div_err[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog: vector table plus hand-written sequences.
// Outputs are sampled 1 time unit after each rising edge.
module tb_clkdiv_prog;

    localparam int N = 4;
    localparam int W = 16;

    logic           clkin = 1'b0;
    logic           rst_n;
    logic [N-1:0]   en;
    logic [N-1:0]   load;
    logic [N*W-1:0] div_in;
    logic [N-1:0]   mode;
    logic [N-1:0]   tick;
    logic [N-1:0]   clkout;
    logic [N-1:0]   div_err;

    clkdiv_prog dut (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .mode    (mode),
        .tick    (tick),
        .clkout  (clkout),
        .div_err (div_err)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        int    d;
        logic  m;
        string clk_pat;
        string tick_pat;
    } vec_t;

    vec_t  vecs[5];
    int    errors = 0;
    int    checks = 0;
    string rec_tick[N];
    string rec_clk[N];

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, got, exp);
        end
    endtask

    task automatic clear_rec();
        for (int c = 0; c < N; c++) begin
            rec_tick[c] = "";
            rec_clk[c]  = "";
        end
    endtask

    task automatic step();
        string s;
        @(posedge clkin);
        #1;
        for (int c = 0; c < N; c++) begin
            s = tick[c] ? "1" : "0";
            rec_tick[c] = {rec_tick[c], s};
            s = clkout[c] ? "1" : "0";
            rec_clk[c] = {rec_clk[c], s};
        end
    endtask

    task automatic set_div(input int ch, input int d);
        div_in[ch*W +: W] = W'(d);
    endtask

    // Stop the channel, load d, and let it become active while stopped.
    task automatic setup_ch(input int ch, input int d);
        en[ch]   = 1'b0;
        load[ch] = 1'b1;
        set_div(ch, d);
        step();
        load[ch] = 1'b0;
        step();
    endtask

    initial begin
        int first;
        int nticks;
        int bad;

        vecs[0] = '{5, 1'b1, "1110011100", "0000100001"};
        vecs[1] = '{5, 1'b0, "0000100001", "0000100001"};
        vecs[2] = '{4, 1'b1, "11001100",   "00010001"};
        vecs[3] = '{3, 1'b1, "110110",     "001001"};
        vecs[4] = '{2, 1'b1, "1010",       "0101"};

        rst_n  = 1'b0;
        en     = '0;
        load   = '0;
        mode   = '0;
        div_in = '0;
        repeat (2) @(posedge clkin);
        #1;
        check_int("reset_tick", int'(tick), 0);
        check_int("reset_clkout", int'(clkout), 0);
        check_int("reset_div_err", int'(div_err), 0);
        rst_n = 1'b1;
        step();

        // Default divisor, pulse mode on channel 0.
        en[0]   = 1'b1;
        mode[0] = 1'b0;
        first   = 0;
        nticks  = 0;
        bad     = 0;
        for (int i = 1; i <= 50001; i++) begin
            @(posedge clkin);
            #1;
            if (tick[0]) begin
                nticks++;
                if (first == 0) first = i;
            end
            if (clkout[0] !== tick[0]) bad++;
        end
        check_int("default_tick_count", nticks, 1);
        check_int("default_first_tick", first, 50000);
        check_int("default_clkout_eq_tick", bad, 0);
        en[0] = 1'b0;
        step();

        // Vector table on channel 1.
        for (int v = 0; v < 5; v++) begin
            setup_ch(1, vecs[v].d);
            mode[1] = vecs[v].m;
            en[1]   = 1'b1;
            clear_rec();
            for (int k = 0; k < vecs[v].clk_pat.len(); k++) step();
            check_str($sformatf("vec%0d_clkout", v), rec_clk[1], vecs[v].clk_pat);
            check_str($sformatf("vec%0d_tick", v), rec_tick[1], vecs[v].tick_pat);
            en[1] = 1'b0;
        end
        check_int("vec_div_err", int'(div_err[1]), 0);

        // D=10, load 3 while count=4: period finishes, then 3s.
        setup_ch(2, 10);
        mode[2] = 1'b0;
        en[2]   = 1'b1;
        clear_rec();
        repeat (4) step();
        load[2] = 1'b1;
        set_div(2, 3);
        step();
        load[2] = 1'b0;
        repeat (15) step();
        check_str("midload_tick", rec_tick[2], "00000000010010010010");
        en[2] = 1'b0;

        // 3 pending, 7 loaded on the terminal edge: 10, then 3, then 7.
        setup_ch(2, 10);
        en[2] = 1'b1;
        clear_rec();
        step();
        load[2] = 1'b1;
        set_div(2, 3);
        step();
        load[2] = 1'b0;
        repeat (7) step();
        load[2] = 1'b1;
        set_div(2, 7);
        step();
        load[2] = 1'b0;
        repeat (18) step();
        check_str("termload_tick", rec_tick[2], "0000000001001000000100000010");
        en[2] = 1'b0;

        // Rejected load sets sticky div_err; a valid load clears it.
        setup_ch(3, 4);
        mode[3] = 1'b0;
        en[3]   = 1'b1;
        clear_rec();
        load[3] = 1'b1;
        set_div(3, 1);
        step();
        load[3] = 1'b0;
        check_int("err_set", int'(div_err[3]), 1);
        step();
        check_int("err_sticky", int'(div_err[3]), 1);
        load[3] = 1'b1;
        set_div(3, 6);
        step();
        load[3] = 1'b0;
        check_int("err_clear", int'(div_err[3]), 0);
        repeat (14) step();
        check_str("err_period_tick", rec_tick[3], "00010000010000010");
        en[3] = 1'b0;

        // All channels concurrently, square mode.
        en   = '0;
        load = '1;
        set_div(0, 2);
        set_div(1, 3);
        set_div(2, 4);
        set_div(3, 65535);
        step();
        load = '0;
        step();
        mode = '1;
        en   = '1;
        clear_rec();
        repeat (12) step();
        check_str("multi_tick0", rec_tick[0], "010101010101");
        check_str("multi_tick1", rec_tick[1], "001001001001");
        check_str("multi_tick2", rec_tick[2], "000100010001");
        check_str("multi_tick3", rec_tick[3], "000000000000");
        check_str("multi_clk0", rec_clk[0], "101010101010");
        check_str("multi_clk1", rec_clk[1], "110110110110");
        check_str("multi_clk2", rec_clk[2], "110011001100");
        check_str("multi_clk3", rec_clk[3], "111111111111");
        step();
        check_int("pre_reset_clkout", int'(clkout), 15);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_int("async_tick", int'(tick), 0);
        check_int("async_clkout", int'(clkout), 0);
        check_int("async_div_err", int'(div_err), 0);
        en = '0;
        @(posedge clkin);
        #1;
        rst_n = 1'b1;

        // Restart re-counts from zero.
        load = '1;
        step();
        load = '0;
        step();
        en = '1;
        clear_rec();
        repeat (12) step();
        check_str("restart_tick0", rec_tick[0], "010101010101");
        check_str("restart_tick1", rec_tick[1], "001001001001");
        check_str("restart_tick2", rec_tick[2], "000100010001");
        check_str("restart_clk3", rec_clk[3], "111111111111");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
